// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the waveform-dump frame scheduler.
package jtframe_dump_pkg;

    // Scheduler states, also exported on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } dump_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_LEN_W       = 16;

    // Window-open test applied on a frame boundary while waiting.
    function automatic logic start_ok(input logic trig_led,
                                      input logic led_pending,
                                      input logic cnt_reached);
        return trig_led ? led_pending : cnt_reached;
    endfunction

endpackage

// File: rtl/jtframe_dump_sched_if.sv
// Harness-side bundle: sync inputs, capture configuration and scheduler status.
interface jtframe_dump_sched_if #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
);
    logic             vs;
    logic             led;
    logic             arm;
    logic [CNT_W-1:0] cfg_start;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_trig_led;
    logic [CNT_W-1:0] frame_cnt;
    logic             dump_en;
    logic             dump_start;
    logic             dump_stop;
    logic             done;
    logic [1:0]       state;

    // Harness side: drives sync/config, observes status.
    modport master (
        output vs, led, arm, cfg_start, cfg_len, cfg_trig_led,
        input  frame_cnt, dump_en, dump_start, dump_stop, done, state
    );

    // Scheduler side.
    modport slave (
        input  vs, led, arm, cfg_start, cfg_len, cfg_trig_led,
        output frame_cnt, dump_en, dump_start, dump_stop, done, state
    );
endinterface

// File: rtl/jtframe_dump_edge.sv
// Resynchronises an asynchronous pin and flags one edge direction.
// The edge flag is combinational from the last sync stage and a history flop,
// so a pin change is seen by the consumer SYNC_STAGES+1 clocks later.
module jtframe_dump_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RISING      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   cur;

    assign cur = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= cur;
        end
    end

    assign edge_o = RISING ? (~hist_q & cur) : (hist_q & ~cur);

endmodule

// File: rtl/jtframe_dump_sched.sv
// Frame-window scheduler: counts VS falling edges and opens a dump window
// either at a programmed frame or after an LED rising edge.
module jtframe_dump_sched
    import jtframe_dump_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LEN_W       = DEF_LEN_W
) (
    input logic                  clk,
    input logic                  rst,
    jtframe_dump_sched_if.slave  bus
);
    logic vs_fall;
    logic led_rise;

    jtframe_dump_edge #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b0)) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (bus.vs),
        .edge_o (vs_fall)
    );

    jtframe_dump_edge #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b1)) u_led_edge (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (bus.led),
        .edge_o (led_rise)
    );

    dump_state_e      state_q,       state_d;
    logic [CNT_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic [LEN_W-1:0] remaining_q,   remaining_d;
    logic [CNT_W-1:0] start_sh_q,    start_sh_d;
    logic [LEN_W-1:0] len_sh_q,      len_sh_d;
    logic             trig_sh_q,     trig_sh_d;
    logic             led_pending_q, led_pending_d;
    logic             abort_q,       abort_d;
    logic             dump_en_q,     dump_en_d;
    logic             dump_start_q,  dump_start_d;
    logic             dump_stop_q,   dump_stop_d;
    logic             done_q,        done_d;

    // State, counters, shadow config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            remaining_q   <= '0;
            start_sh_q    <= '0;
            len_sh_q      <= '0;
            trig_sh_q     <= 1'b0;
            led_pending_q <= 1'b0;
            abort_q       <= 1'b0;
            dump_en_q     <= 1'b0;
            dump_start_q  <= 1'b0;
            dump_stop_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            remaining_q   <= remaining_d;
            start_sh_q    <= start_sh_d;
            len_sh_q      <= len_sh_d;
            trig_sh_q     <= trig_sh_d;
            led_pending_q <= led_pending_d;
            abort_q       <= abort_d;
            dump_en_q     <= dump_en_d;
            dump_start_q  <= dump_start_d;
            dump_stop_q   <= dump_stop_d;
            done_q        <= done_d;
        end
    end

    // Next-state and output decode; window edges only happen on vs_fall.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q + (vs_fall ? CNT_W'(1) : CNT_W'(0));
        remaining_d   = remaining_q;
        start_sh_d    = start_sh_q;
        len_sh_d      = len_sh_q;
        trig_sh_d     = trig_sh_q;
        led_pending_d = led_pending_q;
        abort_d       = abort_q;
        dump_en_d     = dump_en_q;
        dump_start_d  = 1'b0;
        dump_stop_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    start_sh_d    = bus.cfg_start;
                    len_sh_d      = bus.cfg_len;
                    trig_sh_d     = bus.cfg_trig_led;
                    led_pending_d = 1'b0;
                    state_d       = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // An LED edge coinciding with the boundary only counts next frame,
                // because the start test below uses the registered pending flag.
                led_pending_d = led_pending_q | led_rise;
                if (!bus.arm) begin
                    state_d = ST_IDLE;
                end else if (vs_fall &&
                             start_ok(trig_sh_q, led_pending_q, frame_cnt_q >= start_sh_q)) begin
                    state_d      = ST_ACTIVE;
                    dump_en_d    = 1'b1;
                    dump_start_d = 1'b1;
                    remaining_d  = len_sh_q;
                    abort_d      = 1'b0;
                end
            end

            ST_ACTIVE: begin
                // A dropped arm is remembered so the window still ends on a boundary.
                abort_d = abort_q | ~bus.arm;
                if (vs_fall) begin
                    if (abort_q || !bus.arm ||
                        (len_sh_q != '0 && remaining_q == LEN_W'(1))) begin
                        state_d     = ST_DONE;
                        dump_en_d   = 1'b0;
                        dump_stop_d = 1'b1;
                        abort_d     = 1'b0;
                    end else if (len_sh_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (!bus.arm) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
    end

    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.dump_en    = dump_en_q;
    assign bus.dump_start = dump_start_q;
    assign bus.dump_stop  = dump_stop_q;
    assign bus.done       = done_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Directed bench for jtframe_dump_sched with an event scoreboard on the
// 32-bit instance and a 4-bit-counter instance for the wrap case.
module tb_jtframe_dump_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs  = 1'b0;
    logic        led = 1'b0;
    logic        arm = 1'b0;
    logic [31:0] cfg_start = '0;
    logic [15:0] cfg_len   = '0;
    logic        cfg_trig_led = 1'b0;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    jtframe_dump_sched_if #(.CNT_W(32), .LEN_W(16)) bus  ();
    jtframe_dump_sched_if #(.CNT_W(4),  .LEN_W(16)) bus4 ();

    assign bus.vs            = vs;
    assign bus.led           = led;
    assign bus.arm           = arm;
    assign bus.cfg_start     = cfg_start;
    assign bus.cfg_len       = cfg_len;
    assign bus.cfg_trig_led  = cfg_trig_led;
    assign bus4.vs           = vs;
    assign bus4.led          = led;
    assign bus4.arm          = arm;
    assign bus4.cfg_start    = cfg_start[3:0];
    assign bus4.cfg_len      = cfg_len;
    assign bus4.cfg_trig_led = cfg_trig_led;

    jtframe_dump_sched #(.SYNC_STAGES(2), .CNT_W(32), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jtframe_dump_sched #(.SYNC_STAGES(2), .CNT_W(4), .LEN_W(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Expected window events, pushed as each scenario is driven.
    typedef struct {
        bit          stop;
        int unsigned cnt;
    } ev_t;
    ev_t sb_q[$];

    // Observed window events, recorded by the monitor only.
    bit          obs_stop [256];
    bit          obs_both [256];
    int unsigned obs_cnt  [256];
    int          obs_wr = 0;
    int          obs_rd = 0;

    always @(negedge clk) begin
        if (!rst && (bus.dump_start || bus.dump_stop) && obs_wr < 256) begin
            obs_stop[obs_wr] = bus.dump_stop;
            obs_both[obs_wr] = bus.dump_start & bus.dump_stop;
            obs_cnt[obs_wr]  = bus.frame_cnt;
            $display("event %0d: %s frame_cnt=%0d", obs_wr,
                     bus.dump_stop ? "dump_stop" : "dump_start", bus.frame_cnt);
            obs_wr = obs_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit stop, input int unsigned cnt);
        ev_t e;
        e.stop = stop;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    // Pop every expected event and compare it with the next observed one.
    task automatic drain(input string tag);
        ev_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_event_seen"}, 32'(obs_wr > obs_rd), 32'd1);
            if (obs_wr > obs_rd) begin
                chk({tag, "_kind_is_stop"}, 32'(obs_stop[obs_rd]), 32'(e.stop));
                chk({tag, "_frame_cnt"},    obs_cnt[obs_rd],        e.cnt);
                chk({tag, "_start_and_stop"}, 32'(obs_both[obs_rd]), 32'd0);
                obs_rd++;
            end
        end
        chk({tag, "_extra_events"}, 32'(obs_wr - obs_rd), 32'd0);
        obs_rd = obs_wr;
    endtask

    task automatic frame();
        vs = 1'b1;
        repeat (5) @(negedge clk);
        vs = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_frame_cnt",  bus.frame_cnt,  0);
        chk("rst_dump_en",    bus.dump_en,    0);
        chk("rst_dump_start", bus.dump_start, 0);
        chk("rst_dump_stop",  bus.dump_stop,  0);
        chk("rst_done",       bus.done,       0);
        chk("rst_state",      bus.state,      0);

        // Programmed start 5, length 3, armed from reset
        cfg_start = 5; cfg_len = 3; arm = 1'b1;
        push(1'b0, 6);
        push(1'b1, 9);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            frame();
            chk("t1_frame_cnt", bus.frame_cnt, i);
            chk("t1_dump_en",   bus.dump_en, 32'(i >= 6 && i < 9));
            chk("t1_done",      bus.done,    32'(i >= 9));
        end
        chk("t1_state", bus.state, 3);
        drain("t1");

        // Late arm with a start frame already in the past; cfg changes after latch ignored
        arm = 1'b0; cfg_start = 2; cfg_len = 2;
        do_reset();
        repeat (10) frame();
        chk("t2_idle_state", bus.state, 0);
        chk("t2_frame_cnt",  bus.frame_cnt, 10);
        arm = 1'b1;
        push(1'b0, 11);
        push(1'b1, 13);
        repeat (2) @(negedge clk);
        cfg_start = 100;
        repeat (4) frame();
        chk("t2_done", bus.done, 1);
        arm = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_back_idle", bus.state, 0);
        chk("t2_done_clr",  bus.done,  0);
        drain("t2");

        // LED trigger: rise during frame 7 opens at 7->8
        cfg_trig_led = 1'b1; cfg_start = 0; cfg_len = 1;
        do_reset();
        arm = 1'b1;
        repeat (7) frame();
        chk("t3_wait_state", bus.state, 1);
        chk("t3_no_en",      bus.dump_en, 0);
        led = 1'b1;
        push(1'b0, 8);
        push(1'b1, 9);
        frame();
        chk("t3_dump_en", bus.dump_en, 1);
        frame();
        chk("t3_done", bus.done, 1);
        led = 1'b0; arm = 1'b0;
        repeat (2) @(negedge clk);
        drain("t3");

        // LED edge coincident with the boundary counts one frame later
        do_reset();
        arm = 1'b1;
        repeat (3) frame();
        vs = 1'b1;
        repeat (5) @(negedge clk);
        vs = 1'b0; led = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3b_frame_cnt",  bus.frame_cnt, 4);
        chk("t3b_still_wait", bus.state, 1);
        push(1'b0, 5);
        push(1'b1, 6);
        repeat (2) frame();
        led = 1'b0; arm = 1'b0; cfg_trig_led = 1'b0;
        repeat (2) @(negedge clk);
        drain("t3b");

        // Unbounded window aborted mid-frame 20 closes at the next boundary
        cfg_start = 3; cfg_len = 0;
        do_reset();
        arm = 1'b1;
        push(1'b0, 4);
        repeat (20) frame();
        chk("t4_frame_cnt", bus.frame_cnt, 20);
        chk("t4_dump_en",   bus.dump_en, 1);
        vs = 1'b1;
        repeat (2) @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_en_held",     bus.dump_en, 1);
        chk("t4_still_active", bus.state, 2);
        push(1'b1, 21);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_en_clr",    bus.dump_en, 0);
        chk("t4_idle",      bus.state, 0);
        drain("t4");

        // 4-bit counter wraps inside an open window; reset mid-window
        cfg_start = 14; cfg_len = 0;
        do_reset();
        arm = 1'b1;
        push(1'b0, 15);
        repeat (15) frame();
        chk("t5_cnt4_15",   bus4.frame_cnt, 15);
        chk("t5_en4_open",  bus4.dump_en, 1);
        frame();
        chk("t5_cnt4_wrap", bus4.frame_cnt, 0);
        chk("t5_en4_wrap",  bus4.dump_en, 1);
        chk("t5_state4",    bus4.state, 2);
        drain("t5");
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cnt",   bus.frame_cnt, 0);
        chk("t5_rst_en",    bus.dump_en,   0);
        chk("t5_rst_stop",  bus.dump_stop, 0);
        chk("t5_rst_state", bus.state,     0);
        chk("t5_rst_en4",   bus4.dump_en,  0);
        chk("t5_rst_stop4", bus4.dump_stop, 0);
        chk("t5_rst_state4", bus4.state,   0);
        arm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drain("t5_rst");

        // Sub-clock glitch on vs is not counted; pin-to-count latency is 3 clocks
        #1 vs = 1'b1;
        #3 vs = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_glitch_cnt", bus.frame_cnt, 0);
        vs = 1'b1;
        repeat (5) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_lat_early", bus.frame_cnt, 0);
        @(negedge clk);
        chk("t6_lat_exact", bus.frame_cnt, 1);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
